control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the Mini-SRC datapath. It steps through instruction fetch (T0–T2) and execute (T3–T6), decodes IR, and drives every register-enable, bus-select, memory and ALU control line of the `datapath` module. Phase-1 benches drive these lines by hand; this block generates them instead. It sits between `datapath` (IR in, control out) and the top level.

## Interface
Parameters:
- `HALT_OP`, default 5'b11011, opcode that stops the sequencer.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `IR`  in  32  instruction register contents from the datapath. Fields are fixed:
  - opcode = IR[31:27]
  - Ra = IR[26:23]
  - Rb = IR[22:19]
  - Rc = IR[18:15]
- `Stop`  in  1  request to halt at the next instruction boundary.
- `Rin`  out  16  one-hot register load enables; bit n drives `Rnin`.
- `Rout`  out  16  one-hot register bus drivers; bit n drives `Rnout`.
- Single-bit load enables, each `out 1`: `HIin`, `LOin`, `Zin`, `PCin`, `MDRin`, `IRin`, `MARin`, `Yin`.
- Single-bit bus drivers, each `out 1`: `Zhighout`, `Zlowout`, `HIout`, `LOout`, `PCout`, `MDRout`.
- `Read`, `IncPC`  out  1  memory read strobe; PC-increment select.
- `ALU_Control`  out  5  ALU operation code.
- `Run`  out  1  high while sequencing.
- `State`  out  4  current state code, for debug.

## Operation
States and codes:
- IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.

Outputs are a pure function of the state register and IR (Moore). Every output not listed for a state is 0.

Fetch:
- IDLE: all outputs 0. Next state is T0.
- T0: `PCout`, `MARin`, `IncPC`, `Zin`, `ALU_Control`=00000.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
- T2: `MDRout`, `IRin`.

Opcode classes are decoded from IR in T3 onward, because IR is valid once T2 has completed.

Three-register ALU, opcodes 00000–01010 (Ra ← Rb op Rc):
- T3: `Rout[Rb]`, `Yin`.
- T4: `Rout[Rc]`, `Zin`, `ALU_Control`=opcode.
- T5: `Zlowout`, `Rin[Ra]`. T5 ends the instruction.

Mul/div, opcodes 01111 and 10000 (HI:LO ← Ra op Rb):
- T3: `Rout[Ra]`, `Yin`.
- T4: `Rout[Rb]`, `Zin`, `ALU_Control`=opcode.
- T5: `Zlowout`, `LOin`.
- T6: `Zhighout`, `HIin`. T6 ends the instruction.

Unary, opcodes 10001 neg and 10010 not (Ra ← op Rb):
- T3: `Rout[Rb]`, `Zin`, `ALU_Control`=opcode.
- T4: `Zlowout`, `Rin[Ra]`. T4 ends the instruction.

Opcode equal to `HALT_OP`:
- T3 asserts nothing. The next state is HALT.

Any other opcode:
- Treated as a no-op. T3 asserts nothing and ends the instruction.

At the end of an instruction:
- Next state is HALT if `Stop`=1, otherwise T0.

HALT:
- All outputs 0 and `Run`=0.
- Stays in HALT while `Stop`=1. Moves to T0 when `Stop`=0, except after a `HALT_OP` halt, which is left only by `clear`. A 1-bit flag records the halt cause.

`Rin` and `Rout` are never multi-hot. At most one of {`Rout`, `PCout`, `MDRout`, `Zlowout`, `Zhighout`, `HIout`, `LOout`} is nonzero in any state.

## Timing
Reset:
- While `clear`=1: state=IDLE and the halt flag is cleared. All outputs are 0 immediately, independent of `clock`.
- This holds mid-instruction: any T-state aborts combinationally to IDLE.

After reset:
- First rising edge with `clear`=0 goes IDLE→T0.

Instruction latency, from T0 to the next T0 (edges):
- Three-register ALU: 6.
- Mul/div: 7.
- Unary: 5.
- No-op: 4.

Datapath capture:
- Each enable is held for exactly the one cycle of its state. The datapath captures on the rising edge that ends that state.

Memory:
- `Read` is high for the single T1 cycle. Memory must present data on `Mdatain` within that cycle; no wait states.

`Stop`:
- Sampled only on the edge leaving the final state of an instruction. Assertion mid-instruction has no effect until that edge.

`Run`:
- 1 in T0–T6, 0 in IDLE and HALT.

## Test plan
- Reset/first fetch: `clear`=1 for 5 ns mid-cycle → `State`=0 and all outputs 0 without a clock edge; after release, T0 shows `PCout`=`MARin`=`IncPC`=`Zin`=1.
- shra, IR=32'h112B0000 (opcode 00010 per the field split; override the opcode for each ALU code 00000–01010):
  - T3: `Rout`=16'h0020, `Yin`=1.
  - T4: `Rout`=16'h0040, `ALU_Control`=opcode.
  - T5: `Rin`=16'h0004, `Zlowout`=1.
  - Next edge returns to T0.
- mul R3,R4, IR=32'h79A00000:
  - T3: `Rout`=16'h0008.
  - T4: `Rout`=16'h0010, `ALU_Control`=01111.
  - T5: `LOin`=1.
  - T6: `HIin`=1.
  - Then T0.
- neg R1,R2, IR=32'h88900000:
  - T3: `Rout`=16'h0004, `Zin`=1, `ALU_Control`=10001.
  - T4: `Rin`=16'h0002.
  - Then T0.
- Stop/halt:
  - `Stop`=1 raised during T3 of an add → HALT after T5, `Run`=0; drop `Stop` → T0 next edge.
  - IR opcode 11011 → HALT after T3; dropping `Stop` keeps HALT; only `clear` exits.
- Unknown opcode 11111 → T3 with all outputs 0, then T0. Assert `clear` during T4 of an add → IDLE, no `Rin` pulse observed.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini-SRC control unit (fetch T0-T2,
// execute T3-T6) decoding IR into datapath enables and selects.
//
// Ports:
//   clock, clear      rising-edge clock, async active-high reset
//   IR[31:0]          instruction (op 31:27, Ra 26:23, Rb 22:19, Rc 18:15)
//   Stop              halt request, honoured at instruction end
//   Rin/Rout[15:0]    one-hot GPR load enables / bus drivers
//   HIin..Yin         special register load enables
//   Zhighout..MDRout  special register bus drivers
//   Read, IncPC       memory read strobe, PC increment select
//   ALU_Control[4:0]  ALU operation code
//   Run, State[3:0]   sequencing flag, debug state code
module control_sequencer #(
  parameter logic [4:0] HALT_OP = 5'b11011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        HIin,
  output logic        LOin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        MARin,
  output logic        Yin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCout,
  output logic        MDRout,
  output logic        Read,
  output logic        IncPC,
  output logic [4:0]  ALU_Control,
  output logic        Run,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t state;
  logic   halt_lock;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign op = IR[31:27];
  assign ra = IR[26:23];
  assign rb = IR[22:19];
  assign rc = IR[18:15];
  assign unused_ir = ^IR[14:0];

  logic is_halt, is_alu, is_md, is_un;

  // HALT_OP wins if it is ever overridden onto an ALU code
  assign is_halt = (op == HALT_OP);
  assign is_alu = !is_halt && (op <= 5'b01010);
  assign is_md = !is_halt &&
    (op == 5'b01111 || op == 5'b10000);
  assign is_un = !is_halt &&
    (op == 5'b10001 || op == 5'b10010);

  // final execute state of the current instruction
  logic last;
  always_comb begin
    last = 1'b0;
    case (state)
      S_T3: last = !is_halt && !is_alu
                && !is_md && !is_un;
      S_T4: last = !is_alu && !is_md;
      S_T5: last = !is_md;
      S_T6: last = 1'b1;
      default: last = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= S_IDLE;
      halt_lock <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3, S_T4, S_T5, S_T6: begin
          if (state == S_T3 && is_halt) begin
            state     <= S_HALT;
            halt_lock <= 1'b1;
          end else if (last) begin
            state <= Stop ? S_HALT : S_T0;
          end else begin
            state <= state_t'(state + 4'd1);
          end
        end
        S_HALT: begin
          // an opcode halt is sticky until clear
          if (!halt_lock && !Stop)
            state <= S_T0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [15:0] oh(
    input logic [3:0] r
  );
    return 16'd1 << r;
  endfunction

  // Moore decode of state and IR; clear forces IDLE
  // asynchronously so every output drops at once
  always_comb begin
    Rin         = '0;
    Rout        = '0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Zin         = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    MARin       = 1'b0;
    Yin         = 1'b0;
    Zhighout    = 1'b0;
    Zlowout     = 1'b0;
    HIout       = 1'b0;
    LOout       = 1'b0;
    PCout       = 1'b0;
    MDRout      = 1'b0;
    Read        = 1'b0;
    IncPC       = 1'b0;
    ALU_Control = '0;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          Rout = oh(rb);
          Yin  = 1'b1;
        end else if (is_md) begin
          Rout = oh(ra);
          Yin  = 1'b1;
        end else if (is_un) begin
          Rout        = oh(rb);
          Zin         = 1'b1;
          ALU_Control = op;
        end
      end
      S_T4: begin
        if (is_alu) begin
          Rout        = oh(rc);
          Zin         = 1'b1;
          ALU_Control = op;
        end else if (is_md) begin
          Rout        = oh(rb);
          Zin         = 1'b1;
          ALU_Control = op;
        end else if (is_un) begin
          Zlowout = 1'b1;
          Rin     = oh(ra);
        end
      end
      S_T5: begin
        if (is_alu) begin
          Zlowout = 1'b1;
          Rin     = oh(ra);
        end else if (is_md) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
      end
      S_T6: begin
        if (is_md) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign Run = (state != S_IDLE) && (state != S_HALT);
  assign State = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vector table plus randomized
// instruction stream checked against a per-instruction step model.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        Stop;
  logic [15:0] Rin, Rout;
  logic HIin, LOin, Zin, PCin, MDRin, IRin, MARin, Yin;
  logic Zhighout, Zlowout, HIout, LOout, PCout, MDRout;
  logic Read, IncPC, Run;
  logic [4:0] ALU_Control;
  logic [3:0] State;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .Stop(Stop),
    .Rin(Rin), .Rout(Rout),
    .HIin(HIin), .LOin(LOin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .MARin(MARin), .Yin(Yin),
    .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout),
    .PCout(PCout), .MDRout(MDRout),
    .Read(Read), .IncPC(IncPC),
    .ALU_Control(ALU_Control), .Run(Run), .State(State)
  );

  localparam logic [16:0] F_RUN   = 17'd1 << 0;
  localparam logic [16:0] F_INCPC = 17'd1 << 1;
  localparam logic [16:0] F_READ  = 17'd1 << 2;
  localparam logic [16:0] F_MDRO  = 17'd1 << 3;
  localparam logic [16:0] F_PCO   = 17'd1 << 4;
  localparam logic [16:0] F_ZL    = 17'd1 << 7;
  localparam logic [16:0] F_ZH    = 17'd1 << 8;
  localparam logic [16:0] F_YIN   = 17'd1 << 9;
  localparam logic [16:0] F_MARIN = 17'd1 << 10;
  localparam logic [16:0] F_IRIN  = 17'd1 << 11;
  localparam logic [16:0] F_MDRIN = 17'd1 << 12;
  localparam logic [16:0] F_PCIN  = 17'd1 << 13;
  localparam logic [16:0] F_ZIN   = 17'd1 << 14;
  localparam logic [16:0] F_LOIN  = 17'd1 << 15;
  localparam logic [16:0] F_HIIN  = 17'd1 << 16;

  localparam logic [4:0] HOP = 5'b11011;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic [16:0] f;
  } ov_t;

  typedef struct {
    logic [31:0] ir;
    logic        stop;
    ov_t         exp;
  } row_t;

  row_t tbl[$];
  ov_t  q[$];
  int   npass = 0;
  int   ntotal = 0;

  function automatic ov_t mk(input int st,
    input logic [15:0] rin, input logic [15:0] rout,
    input logic [4:0] alu, input logic [16:0] f);
    ov_t o;
    o.st = 4'(st);
    o.rin = rin;
    o.rout = rout;
    o.alu = alu;
    o.f = f;
    return o;
  endfunction

  function automatic ov_t act();
    ov_t o;
    o.st = State;
    o.rin = Rin;
    o.rout = Rout;
    o.alu = ALU_Control;
    o.f = {HIin, LOin, Zin, PCin, MDRin, IRin, MARin, Yin,
           Zhighout, Zlowout, HIout, LOout, PCout, MDRout,
           Read, IncPC, Run};
    return o;
  endfunction

  ov_t IDLE, HALT, FT0, FT1, FT2;

  task automatic check(input string nm, input ov_t e);
    ov_t a;
    a = act();
    ntotal++;
    if (a === e) npass++;
    else $display(
      "FAIL %s: got st=%0d rin=%h rout=%h alu=%b f=%h, want st=%0d rin=%h rout=%h alu=%b f=%h",
      nm, a.st, a.rin, a.rout, a.alu, a.f,
      e.st, e.rin, e.rout, e.alu, e.f);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear(input string nm);
    #2 clear = 1'b1;
    #2 check(nm, IDLE);
    #4 clear = 1'b0;
    @(posedge clock);
    #1;
  endtask

  function automatic void add(input logic [31:0] ir,
    input logic stop, input ov_t e);
    row_t r;
    r.ir = ir;
    r.stop = stop;
    r.exp = e;
    tbl.push_back(r);
  endfunction

  function automatic void add_fetch(input logic [31:0] ir);
    add(ir, 1'b0, FT0);
    add(ir, 1'b0, FT1);
    add(ir, 1'b0, FT2);
  endfunction

  // step model: one entry per cycle of an instruction,
  // state code follows from position in the list
  function automatic void put(input logic [15:0] rin,
    input logic [15:0] rout, input logic [4:0] alu,
    input logic [16:0] f);
    q.push_back(mk(q.size() + 1, rin, rout, alu, f | F_RUN));
  endfunction

  function automatic void build(input logic [31:0] ir);
    int op;
    logic [15:0] a, b, c;
    op = int'(ir[31:27]);
    a = 16'd1 << ir[26:23];
    b = 16'd1 << ir[22:19];
    c = 16'd1 << ir[18:15];
    q.delete();
    q.push_back(FT0);
    q.push_back(FT1);
    q.push_back(FT2);
    if (op == int'(HOP)) begin
      put(0, 0, 0, 0);
    end else if (op <= 10) begin
      put(0, b, 0, F_YIN);
      put(0, c, 5'(op), F_ZIN);
      put(a, 0, 0, F_ZL);
    end else if (op == 15 || op == 16) begin
      put(0, a, 0, F_YIN);
      put(0, b, 5'(op), F_ZIN);
      put(0, 0, 0, F_ZL | F_LOIN);
      put(0, 0, 0, F_ZH | F_HIIN);
    end else if (op == 17 || op == 18) begin
      put(0, b, 5'(op), F_ZIN);
      put(a, 0, 0, F_ZL);
    end else begin
      put(0, 0, 0, 0);
    end
  endfunction

  task automatic run_rand(input logic [31:0] ir,
    output bit locked);
    logic s;
    int k;
    s = 1'b0;
    IR = ir;
    build(ir);
    foreach (q[i]) begin
      check($sformatf("rnd_op%0d_t%0d", ir[31:27], i), q[i]);
      s = ($urandom_range(0, 7) == 0);
      Stop = s;
      step();
    end
    locked = 1'b0;
    if (ir[31:27] == HOP) begin
      locked = 1'b1;
      repeat (3) begin
        check("rnd_halt_lock", HALT);
        Stop = 1'($urandom_range(0, 1));
        step();
      end
    end else if (s) begin
      k = 0;
      do begin
        check("rnd_halt_stop", HALT);
        s = (k < 10) && ($urandom_range(0, 1) == 1);
        Stop = s;
        step();
        k++;
      end while (s);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    bit          lk;
    int          r;

    IDLE = mk(0, 0, 0, 0, 0);
    HALT = mk(8, 0, 0, 0, 0);
    FT0 = mk(1, 0, 0, 0, F_RUN | F_PCO | F_MARIN | F_INCPC | F_ZIN);
    FT1 = mk(2, 0, 0, 0, F_RUN | F_ZL | F_PCIN | F_READ | F_MDRIN);
    FT2 = mk(3, 0, 0, 0, F_RUN | F_MDRO | F_IRIN);

    // three-register ALU, every code on Ra=2 Rb=5 Rc=6
    for (int o = 0; o <= 10; o++) begin
      ir = (32'h112B0000 & 32'h07FF_FFFF) | (32'(o) << 27);
      add_fetch(ir);
      add(ir, 0, mk(4, 0, 16'h0020, 0, F_RUN | F_YIN));
      add(ir, 0, mk(5, 0, 16'h0040, 5'(o), F_RUN | F_ZIN));
      add(ir, 0, mk(6, 16'h0004, 0, 0, F_RUN | F_ZL));
    end
    ir = 32'h79A00000;
    add_fetch(ir);
    add(ir, 0, mk(4, 0, 16'h0008, 0, F_RUN | F_YIN));
    add(ir, 0, mk(5, 0, 16'h0010, 5'b01111, F_RUN | F_ZIN));
    add(ir, 0, mk(6, 0, 0, 0, F_RUN | F_ZL | F_LOIN));
    add(ir, 0, mk(7, 0, 0, 0, F_RUN | F_ZH | F_HIIN));
    ir = 32'h88900000;
    add_fetch(ir);
    add(ir, 0, mk(4, 0, 16'h0004, 5'b10001, F_RUN | F_ZIN));
    add(ir, 0, mk(5, 16'h0002, 0, 0, F_RUN | F_ZL));
    ir = 32'hF8000000;
    add_fetch(ir);
    add(ir, 0, mk(4, 0, 0, 0, F_RUN));
    // add R1,R2,R3 with Stop raised from T3
    ir = 32'h18918000;
    add_fetch(ir);
    add(ir, 1, mk(4, 0, 16'h0004, 0, F_RUN | F_YIN));
    add(ir, 1, mk(5, 0, 16'h0008, 5'b00011, F_RUN | F_ZIN));
    add(ir, 1, mk(6, 16'h0002, 0, 0, F_RUN | F_ZL));
    add(ir, 1, HALT);
    add(ir, 0, HALT);
    // halt opcode: sticky regardless of Stop
    ir = 32'hD8000000;
    add_fetch(ir);
    add(ir, 0, mk(4, 0, 0, 0, F_RUN));
    add(ir, 0, HALT);
    add(ir, 1, HALT);
    add(ir, 0, HALT);
    add(ir, 0, HALT);

    clear = 1'b1;
    Stop = 1'b0;
    IR = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_idle", IDLE);
    clear = 1'b0;
    step();

    foreach (tbl[i]) begin
      IR = tbl[i].ir;
      Stop = tbl[i].stop;
      check($sformatf("tbl%0d", i), tbl[i].exp);
      step();
    end
    check("halt_op_sticky", HALT);

    do_clear("clear_from_halt");
    check("first_fetch_t0", FT0);

    // abort an add during T4 via clear
    IR = 32'h18918000;
    Stop = 1'b0;
    repeat (4) step();
    check("abort_pre_t4",
      mk(5, 0, 16'h0008, 5'b00011, F_RUN | F_ZIN));
    do_clear("abort_idle");
    check("abort_t0", FT0);
    step();
    check("abort_t1", FT1);
    repeat (2) step();

    // from T3 of the restarted add, finish it, land in T0
    repeat (3) step();
    check("resume_t0", FT0);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 19);
      if (r < 9) op = 5'($urandom_range(0, 10));
      else if (r < 12) op = ($urandom_range(0, 1) == 1) ? 5'd15 : 5'd16;
      else if (r < 15) op = ($urandom_range(0, 1) == 1) ? 5'd17 : 5'd18;
      else if (r == 15) op = HOP;
      else op = 5'($urandom_range(0, 31));
      ir = {op, 27'($urandom)};
      run_rand(ir, lk);
      if (lk) begin
        do_clear("rnd_clear");
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
